// File: rtl/inst_sram_responder_pkg.sv
// Shared types and constants for the instruction SRAM responder.
//   state_e             : read FSM states (IDLE, RD_LO, RD_HI)
//   NOP_WORD            : value driven on instruction while ready is low
//   DEFAULT_WAIT_CYCLES : default extra wait cycles per half-word read
package inst_sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD            = 32'h0;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/inst_sram_responder_timer.sv
// Wait-state counter shared by both half-word read states.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start_i  : clear the counter (takes priority over run_i)
//   run_i    : a read cycle is in progress; count up
//   done_o   : high during the last cycle of a half-word read
module sram_read_timer
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic done_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = run_i && (cnt_q == 4'(WAIT_CYCLES));

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction fetch responder backed by a 16-bit asynchronous SRAM.
// Each 32-bit word is read as two half-words (low then high); the last
// fetched word is buffered so repeat fetches are served combinationally.
// Optional macro INST_SRAM_PREFETCH_EN: two-entry buffer plus next-word
// prefetch after every demand fill.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   fetch_req    : fetch stage requests the word at fetch_addr
//   fetch_addr   : byte address, bits [1:0] ignored
//   flush        : abort any in-flight read
//   ready        : instruction valid for fetch_addr this cycle
//   instruction  : fetched word, zero when ready is low
//   sram_addr    : half-word SRAM address
//   sram_dq      : SRAM read data
//   sram_ce_n    : SRAM chip enable (active low)
//   sram_oe_n    : SRAM output enable (active low)
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [31:0]        fetch_addr,
  input  logic               flush,
  output logic               ready,
  output logic [31:0]        instruction,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq,
  output logic               sram_ce_n,
  output logic               sram_oe_n
);

  localparam int unsigned WAW = SRAM_AW - 1;

  state_e         state_q, state_d;
  logic [WAW-1:0] wa, req_addr_q, req_addr_d;
  logic [15:0]    lo_q, lo_d;
  logic [31:0]    buf_word;
  logic           busy, done;
  logic           unused_addr_bits;

  assign wa               = fetch_addr[SRAM_AW:2];
  assign unused_addr_bits = ^{fetch_addr[31:SRAM_AW+1], fetch_addr[1:0]};
  assign busy             = (state_q != IDLE);

  // Counter is held clear while idle and restarts on every half-word boundary.
  sram_read_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start_i(~busy | flush | done),
    .run_i  (busy),
    .done_o (done)
  );

  always_comb begin
    sram_addr = '0;
    if (state_q == RD_LO) begin
      sram_addr = {req_addr_q, 1'b0};
    end else if (state_q == RD_HI) begin
      sram_addr = {req_addr_q, 1'b1};
    end
  end

  assign sram_ce_n   = ~busy;
  assign sram_oe_n   = ~busy;
  assign instruction = ready ? buf_word : NOP_WORD;

`ifdef INST_SRAM_PREFETCH_EN
  logic [1:0]            buf_valid_q, buf_valid_d;
  logic [1:0][WAW-1:0]   buf_addr_q, buf_addr_d;
  logic [1:0][31:0]      buf_data_q, buf_data_d;
  logic                  mru_q, mru_d, tgt_q, tgt_d, pf_q, pf_d;
  logic [1:0]            ent_hit;
  logic                  hit, hit_idx, pf_wait;

  assign ent_hit[0] = buf_valid_q[0] && (buf_addr_q[0] == wa);
  assign ent_hit[1] = buf_valid_q[1] && (buf_addr_q[1] == wa);
  assign hit        = fetch_req && (|ent_hit);
  assign hit_idx    = ~ent_hit[0];
  // The prefetch victim is invalidated at prefetch start, so a hit while
  // prefetching is always to the other entry and can be served directly.
  assign ready      = hit && (~busy || pf_q);
  assign buf_word   = buf_data_q[hit_idx];
  assign pf_wait    = fetch_req && (wa == req_addr_q);

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    lo_d        = lo_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    mru_d       = mru_q;
    tgt_d       = tgt_q;
    pf_d        = pf_q;
    if (ready) begin
      mru_d = hit_idx;
    end
    case (state_q)
      IDLE: begin
        if (fetch_req && !hit && !flush) begin
          req_addr_d = wa;
          tgt_d      = ~mru_q;
          pf_d       = 1'b0;
          state_d    = RD_LO;
        end
      end
      RD_LO, RD_HI: begin
        if (flush || (pf_q && fetch_req && !hit && !pf_wait)) begin
          pf_d    = 1'b0;
          state_d = IDLE;
        end else if (done) begin
          if (state_q == RD_LO) begin
            lo_d    = sram_dq;
            state_d = RD_HI;
          end else begin
            buf_data_d[tgt_q]  = {sram_dq, lo_q};
            buf_addr_d[tgt_q]  = req_addr_q;
            buf_valid_d[tgt_q] = 1'b1;
            if (pf_q) begin
              pf_d    = 1'b0;
              state_d = IDLE;
            end else begin
              mru_d               = tgt_q;
              tgt_d               = ~tgt_q;
              buf_valid_d[~tgt_q] = 1'b0;
              req_addr_d          = req_addr_q + WAW'(1);
              pf_d                = 1'b1;
              state_d             = RD_LO;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= '0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      mru_q       <= 1'b0;
      tgt_q       <= 1'b0;
      pf_q        <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      mru_q       <= mru_d;
      tgt_q       <= tgt_d;
      pf_q        <= pf_d;
    end
  end
`else
  logic           buf_valid_q, buf_valid_d;
  logic [WAW-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]    buf_data_q, buf_data_d;
  logic           hit;

  assign hit      = fetch_req && buf_valid_q && (buf_addr_q == wa);
  assign ready    = ~busy && hit;
  assign buf_word = buf_data_q;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    lo_d        = lo_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    case (state_q)
      IDLE: begin
        if (fetch_req && !hit && !flush) begin
          req_addr_d = wa;
          state_d    = RD_LO;
        end
      end
      RD_LO: begin
        if (flush) begin
          state_d = IDLE;
        end else if (done) begin
          lo_d    = sram_dq;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        if (flush) begin
          state_d = IDLE;
        end else if (done) begin
          buf_data_d  = {sram_dq, lo_q};
          buf_addr_d  = req_addr_q;
          buf_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder (default build, WAIT_CYCLES=2).
// A transaction-level model (buffer contents + cycles elapsed in the current
// read) predicts every output each cycle; directed literals pin the model.
module tb_inst_sram_responder;

  localparam int W  = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          flush;
  logic          ready;
  logic [31:0]   instruction;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq;
  logic          sram_ce_n;
  logic          sram_oe_n;

  int asserts = 0;
  int fails   = 0;

  inst_sram_responder #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .flush      (flush),
    .ready      (ready),
    .instruction(instruction),
    .sram_addr  (sram_addr),
    .sram_dq    (sram_dq),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n)
  );

  always #5 clk = ~clk;

  // SRAM contents: fixed pattern, with the two half-words of word 0x10 pinned.
  function automatic logic [15:0] mem_f(input logic [AW-1:0] a);
    logic [31:0] t;
    if (a == 18'd8) return 16'h1234;
    if (a == 18'd9) return 16'hABCD;
    t = 32'(a) * 32'd965 + 32'd2017;
    return t[15:0];
  endfunction

  assign sram_dq = mem_f(sram_addr);

  // Model state: buffer, and cycles elapsed in the current read (0 = idle).
  logic          m_bv;
  logic [AW-2:0] m_ba;
  logic [31:0]   m_bd;
  logic [AW-2:0] m_req;
  int            m_k;

  task automatic model_reset();
    m_bv  = 1'b0;
    m_ba  = '0;
    m_bd  = '0;
    m_req = '0;
    m_k   = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then compare against the model.
  task automatic drive_check(input logic req, input logic [31:0] addr, input logic fl);
    logic [AW-2:0] wa;
    logic          e_rdy;
    logic [AW-1:0] e_sa;
    @(negedge clk);
    fetch_req  = req;
    fetch_addr = addr;
    flush      = fl;
    #2;
    wa    = addr[AW:2];
    e_rdy = (m_k == 0) && req && m_bv && (m_ba == wa);
    e_sa  = (m_k == 0) ? '0 : {m_req, (m_k > W + 1)};
    chk("ready", 32'(ready), 32'(e_rdy));
    chk("instruction", instruction, e_rdy ? m_bd : 32'h0);
    chk("sram_ce_n", 32'(sram_ce_n), 32'(m_k == 0));
    chk("sram_oe_n", 32'(sram_oe_n), 32'(m_k == 0));
    chk("sram_addr", 32'(sram_addr), 32'(e_sa));
  endtask

  // Advance one clock and apply the same cycle's inputs to the model.
  task automatic advance();
    logic [AW-2:0] wa;
    @(posedge clk);
    wa = fetch_addr[AW:2];
    if (m_k == 0) begin
      if (fetch_req && !flush && !(m_bv && m_ba == wa)) begin
        m_req = wa;
        m_k   = 1;
      end
    end else if (flush) begin
      m_k = 0;
    end else if (m_k == 2 * (W + 1)) begin
      m_bv = 1'b1;
      m_ba = m_req;
      m_bd = {mem_f({m_req, 1'b1}), mem_f({m_req, 1'b0})};
      m_k  = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic run_until_idle(input logic [31:0] addr);
    int n;
    n = 0;
    while (m_k != 0 && n < 20) begin
      drive_check(1'b1, addr, 1'b0);
      advance();
      n++;
    end
    if (m_k != 0) begin
      fails++;
      $display("FAIL idle_timeout: read still busy after %0d cycles", n);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] a;
    rst        = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    flush      = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    drive_check(1'b0, 32'h0, 1'b0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_ce_n", 32'(sram_ce_n), 32'h1);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    advance();

    // Cold miss of 0x10: addr 8 for three cycles, 9 for three, word at T+7.
    drive_check(1'b1, 32'h10, 1'b0);
    chk("cold_ready_T", 32'(ready), 32'h0);
    advance();
    for (int k = 1; k <= 6; k++) begin
      drive_check(1'b1, 32'h10, 1'b0);
      chk("cold_sram_addr", 32'(sram_addr), (k <= 3) ? 32'd8 : 32'd9);
      chk("cold_ready_busy", 32'(ready), 32'h0);
      advance();
    end
    drive_check(1'b1, 32'h10, 1'b0);
    chk("cold_ready_T7", 32'(ready), 32'h1);
    chk("cold_instr_T7", instruction, 32'hABCD1234);
    advance();

    // Repeat hit and low-bit-ignored hit.
    drive_check(1'b1, 32'h10, 1'b0);
    chk("rep_ce_n", 32'(sram_ce_n), 32'h1);
    advance();
    drive_check(1'b1, 32'h13, 1'b0);
    chk("lowbits_ready", 32'(ready), 32'h1);
    chk("lowbits_instr", instruction, 32'hABCD1234);
    advance();

    // Flush in second RD_HI cycle of 0x20.
    for (int k = 0; k <= 4; k++) begin
      drive_check(1'b1, 32'h20, 1'b0);
      advance();
    end
    drive_check(1'b1, 32'h20, 1'b1);
    chk("flush_in_rdhi_addr", 32'(sram_addr), 32'd17);
    advance();
    drive_check(1'b1, 32'h10, 1'b0);
    chk("post_flush_ce_n", 32'(sram_ce_n), 32'h1);
    chk("post_flush_hit", instruction, 32'hABCD1234);
    advance();

    // 0x20 after the flush takes a full miss.
    drive_check(1'b1, 32'h20, 1'b0);
    advance();
    lat = 1;
    while (lat < 20) begin
      drive_check(1'b1, 32'h20, 1'b0);
      if (ready) break;
      advance();
      lat++;
    end
    chk("miss_latency", 32'(lat), 32'd7);
    advance();

    // Reset pulsed mid-RD_HI of a read of 0x40.
    for (int k = 0; k <= 4; k++) begin
      drive_check(1'b1, 32'h40, 1'b0);
      advance();
    end
    drive_check(1'b1, 32'h40, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(ready), 32'h0);
    chk("arst_instr", instruction, 32'h0);
    chk("arst_ce_n", 32'(sram_ce_n), 32'h1);
    chk("arst_oe_n", 32'(sram_oe_n), 32'h1);
    chk("arst_sram_addr", 32'(sram_addr), 32'h0);
    @(posedge clk);
    model_reset();
    #1 rst = 1'b0;

    // Address 0 misses after reset.
    drive_check(1'b1, 32'h0, 1'b0);
    chk("post_rst_miss", 32'(ready), 32'h0);
    advance();
    drive_check(1'b1, 32'h0, 1'b0);
    chk("post_rst_read_ce_n", 32'(sram_ce_n), 32'h0);
    advance();
    run_until_idle(32'h0);

    // Address switched 0x20 -> 0x30 during RD_LO without flush.
    drive_check(1'b1, 32'h20, 1'b0);
    advance();
    drive_check(1'b1, 32'h20, 1'b0);
    advance();
    drive_check(1'b1, 32'h30, 1'b0);
    chk("switch_keeps_addr", 32'(sram_addr), 32'd16);
    advance();
    drive_check(1'b1, 32'h30, 1'b0);
    advance();
    drive_check(1'b1, 32'h30, 1'b0);
    chk("switch_hi_addr", 32'(sram_addr), 32'd17);
    advance();
    run_until_idle(32'h30);
    drive_check(1'b1, 32'h30, 1'b0);
    chk("switch_new_miss", 32'(ready), 32'h0);
    advance();
    drive_check(1'b1, 32'h30, 1'b0);
    chk("switch_new_read", 32'(sram_addr), 32'd24);
    advance();
    run_until_idle(32'h30);

    // Randomized traffic over a small word set plus the top word.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h0007_FFFC;
      else a = 32'($urandom_range(0, 6)) << 2;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 32'hFFF8_0000;
      drive_check($urandom_range(0, 4) != 0, a, $urandom_range(0, 9) == 0);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
